recon_tx_framer: RTL



---
 rtl/recon_tx_framer.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/recon_tx_framer.sv
// recon_tx_framer
//
// Takes one bitstream request (address, byte length, id) at a time and turns
// it into a DMA read. The returned read data is cut into output frames of at
// most SEG_BEATS payload beats. Each frame starts with a header beat that
// describes the segment address, the id and the remaining byte count.
//
// Optional feature: define RECON_TX_ERR_EN to act on DMA status errors.
// With the macro defined, an error sets a sticky err flag and raises tuser on
// the next tlast beat. If no beat is left to carry the flag, a header-only
// tlast beat is sent instead. Without the macro, err and m_axis_tuser are
// tied low and status errors are ignored.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_req_*                         bitstream request (valid/ready)
//   m_axis_read_desc_*              DMA read descriptor out (valid/ready)
//   s_axis_read_desc_status_*       DMA completion status in (valid only)
//   s_axis_t*                       DMA read data in
//   m_axis_t*                       framed output stream
//   busy                            high whenever a request is in progress
//   err                             sticky DMA error flag

module recon_tx_framer #(
  parameter int unsigned DATA_WIDTH         = 512,
  parameter int unsigned KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH         = 34,
  parameter int unsigned DMA_DESC_LEN_WIDTH = 20,
  parameter int unsigned DMA_DESC_TAG_WIDTH = 8,
  parameter int unsigned SEG_BEATS          = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [ADDR_WIDTH-1:0]         s_req_addr,
  input  logic [31:0]                   s_req_len,
  input  logic [7:0]                    s_req_id,
  input  logic                          s_req_valid,
  output logic                          s_req_ready,

  output logic [ADDR_WIDTH-1:0]         m_axis_read_desc_addr,
  output logic [DMA_DESC_LEN_WIDTH-1:0] m_axis_read_desc_len,
  output logic [DMA_DESC_TAG_WIDTH-1:0] m_axis_read_desc_tag,
  output logic                          m_axis_read_desc_valid,
  input  logic                          m_axis_read_desc_ready,

  input  logic [DMA_DESC_TAG_WIDTH-1:0] s_axis_read_desc_status_tag,
  input  logic [3:0]                    s_axis_read_desc_status_error,
  input  logic                          s_axis_read_desc_status_valid,

  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,

  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,

  output logic                          busy,
  output logic                          err
);

`ifdef RECON_TX_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam int unsigned CntW     = (SEG_BEATS > 1) ? $clog2(SEG_BEATS) : 1;
  localparam logic [31:0] SegBytes = 32'(SEG_BEATS * KEEP_WIDTH);

  typedef enum logic [2:0] {StIdle, StDesc, StHdr, StData, StStatus} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [31:0]                   rem_q, rem_d;
  logic [7:0]                    id_q, id_d;
  logic [DMA_DESC_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic                          status_seen_q, status_seen_d;
  logic                          err_q, err_d;
  // err_pend: an error not yet reported on tuser.
  // err_vis: the copy that drives tuser, frozen while an output beat is stalled.
  logic                          err_pend_q, err_pend_d;
  logic                          err_vis_q, err_vis_d;

  logic                          status_hit;
  logic                          err_evt;
  logic                          seg_end;
  logic                          out_xfer;
  logic                          stalled;
  logic [DATA_WIDTH-1:0]         hdr_beat;

  // Only status for the request in flight counts; IDLE has no request in flight.
  assign status_hit = s_axis_read_desc_status_valid && (state_q != StIdle) &&
                      (s_axis_read_desc_status_tag == tag_q);
  assign err_evt    = ErrEn && status_hit && (s_axis_read_desc_status_error != 4'h0);
  assign seg_end    = (cnt_q == CntW'(SEG_BEATS - 1));
  assign out_xfer   = m_axis_tvalid && m_axis_tready;
  assign stalled    = m_axis_tvalid && !m_axis_tready;
  assign busy       = (state_q != StIdle);
  assign err        = ErrEn && err_q;

  always_comb begin
    hdr_beat        = '0;
    hdr_beat[1:0]   = 2'b01;
    hdr_beat[2]     = 1'b1;
    hdr_beat[36:3]  = 34'(addr_q);
    hdr_beat[44:37] = id_q;
    hdr_beat[76:45] = rem_q;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      rem_q         <= '0;
      id_q          <= '0;
      tag_q         <= '0;
      cnt_q         <= '0;
      status_seen_q <= 1'b0;
      err_q         <= 1'b0;
      err_pend_q    <= 1'b0;
      err_vis_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      id_q          <= id_d;
      tag_q         <= tag_d;
      cnt_q         <= cnt_d;
      status_seen_q <= status_seen_d;
      err_q         <= err_d;
      err_pend_q    <= err_pend_d;
      err_vis_q     <= err_vis_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    id_d          = id_q;
    tag_d         = tag_q;
    cnt_d         = cnt_q;
    status_seen_d = status_seen_q | status_hit;
    err_d         = err_q | err_evt;
    err_pend_d    = err_pend_q;
    // tuser only rises on a beat that reports a pending error
    if (out_xfer && m_axis_tuser) begin
      err_pend_d = 1'b0;
    end
    err_pend_d = err_pend_d | err_evt;
    err_vis_d  = stalled ? err_vis_q : err_pend_d;

    unique case (state_q)
      StIdle: begin
        if (s_req_valid) begin
          status_seen_d = 1'b0;
          err_pend_d    = 1'b0;
          err_vis_d     = 1'b0;
          // A zero-length request is accepted and dropped
          if (s_req_len != 32'd0) begin
            addr_d  = s_req_addr;
            rem_d   = s_req_len;
            id_d    = s_req_id;
            tag_d   = tag_q + DMA_DESC_TAG_WIDTH'(1);
            cnt_d   = '0;
            state_d = StDesc;
          end
        end
      end
      StDesc: begin
        if (m_axis_read_desc_ready) begin
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (m_axis_tready) begin
          state_d = StData;
        end
      end
      StData: begin
        if (out_xfer) begin
          if (s_axis_tlast) begin
            cnt_d   = '0;
            state_d = (status_seen_d && !err_pend_d) ? StIdle : StStatus;
          end else if (seg_end) begin
            addr_d  = addr_q + ADDR_WIDTH'(SegBytes);
            rem_d   = rem_q - SegBytes;
            cnt_d   = '0;
            state_d = StHdr;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StStatus: begin
        if (status_seen_d && !err_pend_d) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    s_req_ready            = 1'b0;
    m_axis_read_desc_valid = 1'b0;
    m_axis_read_desc_addr  = '0;
    m_axis_read_desc_len   = '0;
    m_axis_read_desc_tag   = '0;
    s_axis_tready          = 1'b0;
    m_axis_tvalid          = 1'b0;
    m_axis_tdata           = '0;
    m_axis_tkeep           = '0;
    m_axis_tlast           = 1'b0;
    m_axis_tuser           = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted so every output reads zero in reset
        s_req_ready = rst_n;
      end
      StDesc: begin
        m_axis_read_desc_valid = 1'b1;
        m_axis_read_desc_addr  = addr_q;
        m_axis_read_desc_len   = rem_q[DMA_DESC_LEN_WIDTH-1:0];
        m_axis_read_desc_tag   = tag_q;
      end
      StHdr: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_beat;
        m_axis_tkeep  = '1;
      end
      StData: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tlast  = seg_end || s_axis_tlast;
        m_axis_tuser  = ErrEn && err_vis_q && (seg_end || s_axis_tlast);
      end
      StStatus: begin
        // The error arrived after the last payload beat: report it on a
        // header-only tlast beat
        if (ErrEn && err_pend_q) begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = hdr_beat;
          m_axis_tkeep  = '1;
          m_axis_tlast  = 1'b1;
          m_axis_tuser  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
